// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, state encoding and frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  // Whole-frame duration in clk2 cycles, start bit through last stop bit.
  function automatic int frame_len(input int data_bits, input int clks_per_bit,
                                   input int parity_mode, input int stop_bits);
    return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits)
           * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk2,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] tick_cnt;

  assign bit_end = (tick_cnt == CW'(CLKS_PER_BIT - 1));

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk2) begin
    if (reset || clear || bit_end) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stops.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk2,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TXdataOut,
  output logic                 tx_busy
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                 break_req
`endif
);

  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_t          state, state_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic                 par, par_nxt;
  logic                 line, line_nxt;
  logic                 ready_en;
  logic                 bit_end;
  logic                 last_stop;
  logic                 transfer;
  logic                 break_now;
  logic                 brk;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk2   (clk2),
    .reset  (reset),
    .clear  (transfer || (state == IDLE)),
    .bit_end(bit_end)
  );

`ifdef UART_TX_BREAK_EN
  assign break_now = break_req;

  // Break only takes the line once the frame has fully drained.
  always_ff @(posedge clk2) begin
    if (reset) brk <= 1'b0;
    else       brk <= break_now && ((state == IDLE) || last_stop);
  end
`else
  assign break_now = 1'b0;
  assign brk       = 1'b0;
`endif

  assign last_stop = (state == STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign tx_ready  = ready_en && !brk && !break_now && ((state == IDLE) || last_stop);
  assign transfer  = tx_valid && tx_ready;
  assign tx_busy   = (state != IDLE);
  assign TXdataOut = line;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    line_nxt    = line;

    case (state)
      IDLE: line_nxt = !break_now;
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          line_nxt    = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_nxt = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              state_nxt = PARITY;
              line_nxt  = par;
            end else begin
              state_nxt = STOP;
              line_nxt  = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
            line_nxt    = shreg[0];
            shreg_nxt   = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          line_nxt    = 1'b1;
          bit_cnt_nxt = '0;
        end
      end
      STOP: begin
        if (last_stop) begin
          state_nxt = IDLE;
          line_nxt  = !break_now;
        end else if (bit_end) begin
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A transfer overrides IDLE or the final stop cycle: start bit appears next cycle.
    if (transfer) begin
      state_nxt   = START;
      line_nxt    = 1'b0;
      shreg_nxt   = tx_data;
      bit_cnt_nxt = '0;
      par_nxt     = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
    end
  end

  always_ff @(posedge clk2) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      par      <= 1'b0;
      line     <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par      <= par_nxt;
      line     <= line_nxt;
      ready_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations checked cycle by cycle against a
// queue-based line model; define UART_TX_BREAK_EN to include the break scenario.
module tb_uart_tx_frame;

  localparam int NI  = 4;
  localparam int CPB = 16;
  localparam int DB [NI] = '{8, 8, 8, 5};
  localparam int PM [NI] = '{0, 1, 2, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic            clk2 = 1'b0;
  logic            reset;
  logic [NI-1:0]   valid;
  logic [8:0]      data [NI];
  logic [NI-1:0]   ready, txd, busy;
  logic            brk_req;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  // model state
  bit mq [NI][$];
  bit mbrk [NI];
  bit men = 1'b0;

  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frame #(
      .DATA_BITS   (DB[g]),
      .CLKS_PER_BIT(CPB),
      .PARITY_MODE (PM[g]),
      .STOP_BITS   (SB[g])
    ) dut (
      .clk2     (clk2),
      .reset    (reset),
      .tx_valid (valid[g]),
      .tx_data  (data[g][DB[g]-1:0]),
      .tx_ready (ready[g]),
      .TXdataOut(txd[g]),
      .tx_busy  (busy[g])
`ifdef UART_TX_BREAK_EN
      ,
      .break_req(brk_req)
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected line levels for a whole frame, one entry per clk2 cycle.
  task automatic push_frame(input int i, input logic [8:0] w);
    logic [8:0] m;
    int ones;
    m    = w & 9'((1 << DB[i]) - 1);
    ones = $countones(m);
    repeat (CPB) mq[i].push_back(1'b0);
    for (int b = 0; b < DB[i]; b++)
      repeat (CPB) mq[i].push_back(m[b]);
    if (PM[i] == 1) repeat (CPB) mq[i].push_back((ones % 2) == 1);
    if (PM[i] == 2) repeat (CPB) mq[i].push_back((ones % 2) == 0);
    repeat (SB[i] * CPB) mq[i].push_back(1'b1);
  endtask

  always @(negedge clk2) begin
    bit exp_line, exp_rdy, exp_busy, nb;
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        exp_busy = (mq[i].size() > 0);
        exp_line = exp_busy ? mq[i][0] : !mbrk[i];
        exp_rdy  = men && !mbrk[i] && !brk_req && (mq[i].size() <= 1);
        check($sformatf("line%0d", i),  txd[i],   exp_line);
        check($sformatf("ready%0d", i), ready[i], exp_rdy);
        check($sformatf("busy%0d", i),  busy[i],  exp_busy);
        if (reset) begin
          mq[i].delete();
          mbrk[i] = 1'b0;
        end else begin
          nb = brk_req && (mq[i].size() <= 1);
          if (mq[i].size() > 0) void'(mq[i].pop_front());
          if (valid[i] && exp_rdy) push_frame(i, data[i]);
          mbrk[i] = nb;
        end
      end
      men = !reset;
    end
  end

  // Offer w on instance i until accepted; returns at #1 after the transfer edge with valid still high.
  task automatic xfer(input int i, input logic [8:0] w, output int t);
    int n;
    valid[i] = 1'b1;
    data[i]  = w;
    n = 0;
    @(negedge clk2);
    while (!ready[i] && n < 1000) begin
      @(negedge clk2);
      n++;
    end
    check($sformatf("accept%0d", i), ready[i], 1'b1);
    @(posedge clk2);
    #1;
    t = cyc;
  endtask

  task automatic measure(input int i, output int n);
    n = 0;
    while (busy[i] && n < 400) begin
      @(posedge clk2);
      #1;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, n, i, j;
    reset   = 1'b1;
    valid   = '0;
    brk_req = 1'b0;
    for (int k = 0; k < NI; k++) data[k] = '0;
    repeat (3) @(posedge clk2);
    #1 chk_on = 1'b1;
    check("rst_line", txd, 4'hf);
    check("rst_ready", ready, 4'h0);
    check("rst_busy", busy, 4'h0);
    @(posedge clk2);
    #1 reset = 1'b0;
    @(posedge clk2);
    #1;
    check("ready_after_rst", ready, 4'hf);

    // 8N1 frame of 0x95
    xfer(0, 9'h095, t1);
    valid[0] = 1'b0;
    measure(0, n);
    check("len_8n1", n, 160);

    // even parity 0xB9, odd parity 0xC3
    xfer(1, 9'h0b9, t1);
    valid[1] = 1'b0;
    measure(1, n);
    check("len_even", n, 176);
    xfer(2, 9'h0c3, t1);
    valid[2] = 1'b0;
    measure(2, n);
    check("len_odd", n, 176);

    // 5 data bits, 2 stop bits
    xfer(3, 9'h015, t1);
    valid[3] = 1'b0;
    measure(3, n);
    check("len_5n2", n, 128);

    // back-to-back frames with valid held high
    xfer(0, 9'h0c3, t1);
    xfer(0, 9'h0cc, t2);
    valid[0] = 1'b0;
    check("b2b_gap", t2 - t1, 160);
    measure(0, n);

    // reset mid-frame at cycle 70
    xfer(0, 9'h05a, t1);
    valid[0] = 1'b0;
    repeat (70) @(posedge clk2);
    #1 reset = 1'b1;
    @(posedge clk2);
    #1;
    check("midrst_line", txd[0], 1'b1);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_ready", ready[0], 1'b0);
    reset = 1'b0;
    @(posedge clk2);
    #1;
    check("midrst_ready_up", ready[0], 1'b1);
    xfer(0, 9'h1a7, t1);
    valid[0] = 1'b0;
    measure(0, n);
    check("len_after_rst", n, 160);

    // randomized traffic with stray valid pulses on other instances
    for (int k = 0; k < 40; k++) begin
      i = $urandom_range(0, NI - 1);
      j = (i + $urandom_range(1, NI - 1)) % NI;
      valid[j] = 1'b1;
      data[j]  = 9'($urandom);
      @(posedge clk2);
      #1 valid[j] = 1'b0;
      data[j] = 9'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk2);
      #1;
      xfer(i, 9'($urandom), t1);
      if ($urandom_range(0, 1) == 1) xfer(i, 9'($urandom), t2);
      valid[i] = 1'b0;
      data[i]  = 9'($urandom);
    end
    repeat (400) @(posedge clk2);
    #1;

`ifdef UART_TX_BREAK_EN
    // break raised mid-frame: frame drains, then line held low; valid ignored
    xfer(0, 9'h0e1, t1);
    valid[0] = 1'b0;
    repeat (40) @(posedge clk2);
    #1 brk_req = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 9'h03c;
    repeat (300) @(posedge clk2);
    #1;
    check("brk_line", txd[0], 1'b0);
    check("brk_ready", ready[0], 1'b0);
    check("brk_busy", busy[0], 1'b0);
    brk_req  = 1'b0;
    valid[0] = 1'b0;
    @(posedge clk2);
    #1;
    check("brk_release_line", txd[0], 1'b1);
    check("brk_release_ready", ready[0], 1'b1);
    xfer(0, 9'h0a5, t1);
    valid[0] = 1'b0;
    measure(0, n);
    check("len_after_brk", n, 160);
`endif

    repeat (5) @(posedge clk2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
